// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline, with a multi-cycle EX handshake and a stall counter.
// Optional EX_WAIT watchdog is enabled by defining PIPELINE_CTRL_WDOG_EN.
module pipeline_ctrl #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_start,
  input  logic        ex_done,
  input  logic        stallreq_mem,
  input  logic        excp_valid,
  input  logic [31:0] excp_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        busy,
  output logic [31:0] stall_cnt,
  output logic        wdog_timeout
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_EX_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        wdog_fire_s;

  // Zero-latency stall/flush decode; outputs are held quiet while in reset
  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'h0000_0000;
    if (rst) begin
      stall = 6'b000000;
    end else if (excp_valid) begin
      flush  = 1'b1;
      new_pc = excp_pc;
    end else if (stallreq_mem) begin
      stall = 6'b011111;
    end else if (((state_q == ST_EX_WAIT) && !ex_done) ||
                 ((state_q == ST_RUN) && ex_start)) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end else begin
      stall = 6'b000000;
    end
  end

  // Next state; a start that completes in the same cycle never leaves RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (ex_start && !excp_valid && !ex_done) begin
          state_d = ST_EX_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_EX_WAIT: begin
        if (ex_done || excp_valid || wdog_fire_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_EX_WAIT;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall != 6'b000000) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = (state_q == ST_EX_WAIT);
  assign stall_cnt = stall_cnt_q;

`ifdef PIPELINE_CTRL_WDOG_EN
  localparam int WW = ($clog2(WDOG_CYCLES + 1) > 8) ? $clog2(WDOG_CYCLES + 1) : 8;

  logic [WW-1:0] wdog_cnt_q;
  logic          wdog_timeout_q;

  // wdog_cnt_q holds the number of EX_WAIT cycles already completed
  assign wdog_fire_s = (state_q == ST_EX_WAIT) && !ex_done &&
                       (wdog_cnt_q == WW'(WDOG_CYCLES - 1));

  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q     <= '0;
      wdog_timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_EX_WAIT) begin
        wdog_cnt_q <= wdog_cnt_q + {{(WW-1){1'b0}}, 1'b1};
      end else begin
        wdog_cnt_q <= '0;
      end
      if (wdog_fire_s) begin
        wdog_timeout_q <= 1'b1;
      end
    end
  end

  assign wdog_timeout = wdog_timeout_q;
`else
  assign wdog_fire_s  = 1'b0;
  assign wdog_timeout = 1'b0;
`endif

endmodule
